// File: rtl/seq_detect_scheduler.sv
// ============================================================================
// Module   : seq_detect_scheduler
// Brief    : Serializes parallel words into a "101" detector and returns the
//            per-word hit count over a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_scheduler #(
   parameter int WORD_W    = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CNT_W    = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              det_data_in,
   input  logic              det_seq_detected,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_any,
   output logic              busy
);

   localparam int                c_BC_W     = $clog2(WORD_W);
   localparam logic [c_BC_W-1:0] c_LAST_BIT = c_BC_W'(WORD_W - 1);
   localparam logic [c_BC_W-1:0] c_FLUSH_END = c_BC_W'(1);
   localparam logic [c_BC_W-1:0] c_BC_ONE   = c_BC_W'(1);
   localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLUSH = 3'd1,
      SHIFT = 3'd2,
      TAIL  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WORD_W-1:0]   r_shift;
   logic [c_BC_W-1:0]   r_bit_cnt;
   logic [CNT_W-1:0]    r_count;
   logic                r_det_data;
   logic                w_head;
   logic [WORD_W-1:0]   w_shift_nxt;
   logic [CNT_W-1:0]    w_count_acc;

   // Head bit and shift direction follow the configured serial order.
   if (MSB_FIRST) begin : g_msb_first
      assign w_head      = r_shift[WORD_W-1];
      assign w_shift_nxt = {r_shift[WORD_W-2:0], 1'b0};
   end else begin : g_lsb_first
      assign w_head      = r_shift[0];
      assign w_shift_nxt = {1'b0, r_shift[WORD_W-1:1]};
   end

   assign w_count_acc = (det_seq_detected && (r_count != c_CNT_MAX)) ?
                        (r_count + c_CNT_ONE) : r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nxt = FLUSH;
         end
         FLUSH: if (r_bit_cnt == c_FLUSH_END) w_state_nxt = SHIFT;
         SHIFT: if (r_bit_cnt == c_LAST_BIT) w_state_nxt = TAIL;
         TAIL:  w_state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // det_data_in is loaded one edge ahead so each bit occupies a full cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_count    <= '0;
         r_det_data <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_det_data <= 1'b0;
               if (in_valid) begin
                  r_shift   <= in_word;
                  r_bit_cnt <= '0;
                  r_count   <= '0;
               end
            end
            FLUSH: begin
               if (r_bit_cnt == c_FLUSH_END) begin
                  r_det_data <= w_head;
                  r_shift    <= w_shift_nxt;
                  r_bit_cnt  <= '0;
               end else begin
                  r_det_data <= 1'b0;
                  r_bit_cnt  <= r_bit_cnt + c_BC_ONE;
               end
            end
            SHIFT: begin
               r_count <= w_count_acc;
               if (r_bit_cnt == c_LAST_BIT) begin
                  r_det_data <= 1'b0;
                  r_bit_cnt  <= '0;
               end else begin
                  r_det_data <= w_head;
                  r_shift    <= w_shift_nxt;
                  r_bit_cnt  <= r_bit_cnt + c_BC_ONE;
               end
            end
            TAIL: begin
               r_count    <= w_count_acc;
               r_det_data <= 1'b0;
            end
            default: r_det_data <= 1'b0;
         endcase
      end
   end

   assign det_data_in = r_det_data;
   assign out_count   = r_count;
   assign out_any     = (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_scheduler.sv
// ============================================================================
// Module   : tb_seq_detect_scheduler
// Brief    : Self-checking bench; MSB-first and LSB-first instances each drive
//            a behavioural "101" detector, results checked against a stream count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_word;
   logic       out_ready;

   logic       m_in_ready, m_det, m_seq, m_out_valid, m_out_any, m_busy;
   logic [3:0] m_out_count;
   logic       l_in_ready, l_det, l_seq, l_out_valid, l_out_any, l_busy;
   logic [3:0] l_out_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_detect_scheduler #(.WORD_W(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
      .in_word(in_word), .det_data_in(m_det), .det_seq_detected(m_seq),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_count(m_out_count),
      .out_any(m_out_any), .busy(m_busy));

   seq_detect_scheduler #(.WORD_W(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
      .in_word(in_word), .det_data_in(l_det), .det_seq_detected(l_seq),
      .out_valid(l_out_valid), .out_ready(out_ready), .out_count(l_out_count),
      .out_any(l_out_any), .busy(l_busy));

   // Detectors without reset: the flag is the last three sampled bits equal to 101.
   logic [2:0] m_hist;
   logic [2:0] l_hist;
   initial begin
      m_hist = 3'($urandom);
      l_hist = 3'($urandom);
   end
   always @(posedge clk) begin
      m_hist <= {m_hist[1:0], m_det};
      l_hist <= {l_hist[1:0], l_det};
   end
   assign m_seq = (m_hist == 3'b101);
   assign l_seq = (l_hist == 3'b101);

   function automatic int ref_count(input logic [7:0] w, input bit msb);
      int   n = 0;
      logic s [8];
      for (int i = 0; i < 8; i++) s[i] = msb ? w[7-i] : w[i];
      for (int i = 0; i < 6; i++) if (s[i] && !s[i+1] && s[i+2]) n++;
      return n;
   endfunction

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({m_in_ready, m_out_valid, m_out_count, m_out_any, m_det, m_busy} !== 9'b1_0_0000_0_0_0) begin
         errors++;
         $display("FAIL %s msb: rdy=%b vld=%b cnt=%0d any=%b det=%b busy=%b, required 1 0 0 0 0 0",
                  tag, m_in_ready, m_out_valid, m_out_count, m_out_any, m_det, m_busy);
      end
      checks++;
      if ({l_in_ready, l_out_valid, l_out_count, l_out_any, l_det, l_busy} !== 9'b1_0_0000_0_0_0) begin
         errors++;
         $display("FAIL %s lsb: rdy=%b vld=%b cnt=%0d any=%b det=%b busy=%b, required 1 0 0 0 0 0",
                  tag, l_in_ready, l_out_valid, l_out_count, l_out_any, l_det, l_busy);
      end
   endtask

   // Entered and left at a falling edge with both instances idle.
   task automatic run_word(input logic [7:0] w, input int hold, input bit poke);
      int   n;
      bit   got;
      int   em, el;
      logic saved_ready;
      em = ref_count(w, 1'b1);
      el = ref_count(w, 1'b0);
      checks++;
      if (!(m_in_ready && l_in_ready)) begin
         errors++;
         $display("FAIL accept_ready: msb=%b lsb=%b, required 1 1", m_in_ready, l_in_ready);
      end
      in_valid = 1'b1;
      in_word  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_word  = 8'($urandom);
      n   = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (m_out_valid) got = 1'b1;
      end
      checks++;
      if (!got || n != 12 || !l_out_valid) begin
         errors++;
         $display("FAIL latency word=%h: out_valid at cycle %0d (seen=%b lsb=%b), required cycle 12",
                  w, n, got, l_out_valid);
      end
      for (int h = 0; h <= hold; h++) begin
         checks++;
         if (m_out_count !== 4'(em) || m_out_any !== (em != 0) || !m_out_valid || m_in_ready || m_det) begin
            errors++;
            $display("FAIL msb_result word=%h hold=%0d: cnt=%0d any=%b vld=%b rdy=%b det=%b, required cnt=%0d any=%b vld=1 rdy=0 det=0",
                     w, h, m_out_count, m_out_any, m_out_valid, m_in_ready, m_det, em, em != 0);
         end
         checks++;
         if (l_out_count !== 4'(el) || l_out_any !== (el != 0) || !l_out_valid || l_in_ready || l_det) begin
            errors++;
            $display("FAIL lsb_result word=%h hold=%0d: cnt=%0d any=%b vld=%b rdy=%b det=%b, required cnt=%0d any=%b vld=1 rdy=0 det=0",
                     w, h, l_out_count, l_out_any, l_out_valid, l_in_ready, l_det, el, el != 0);
         end
         if (h < hold) begin
            if (poke) begin
               in_valid = 1'b1;
               in_word  = 8'($urandom);
            end
            @(negedge clk);
         end
      end
      in_valid    = 1'b0;
      saved_ready = out_ready;
      out_ready   = 1'b1;
      @(posedge clk);
      #1;
      out_ready = saved_ready;
      @(negedge clk);
      checks++;
      if (m_out_valid || l_out_valid || m_busy || l_busy || !m_in_ready || !l_in_ready) begin
         errors++;
         $display("FAIL handoff word=%h: vld=%b/%b busy=%b/%b rdy=%b/%b, required vld=0 busy=0 rdy=1",
                  w, m_out_valid, l_out_valid, m_busy, l_busy, m_in_ready, l_in_ready);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_word   = 8'h00;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset_idle");
   endtask

   task automatic test_directed();
      run_word(8'b1010_1000, 0, 1'b0);
      run_word(8'b1011_0101, 0, 1'b0);
      run_word(8'hFF, 0, 1'b0);
      run_word(8'h00, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_word(8'b0101_0101, 0, 1'b0);
      run_word(8'hA0, 0, 1'b0);
   endtask

   task automatic test_hold_done();
      run_word(8'b1011_0101, 5, 1'b1);
   endtask

   task automatic test_ready_early();
      out_ready = 1'b1;
      run_word(8'b1010_0101, 0, 1'b0);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_shift();
      in_valid = 1'b1;
      in_word  = 8'hAA;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (!m_busy || !l_busy) begin
         errors++;
         $display("FAIL mid_shift_busy: msb=%b lsb=%b, required 1 1", m_busy, l_busy);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset_mid_shift");
      run_word(8'b1010_1000, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         run_word(8'($urandom), $urandom_range(0, 3), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold_done();
      test_ready_early();
      test_reset_mid_shift();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
